// File: rtl/mc_sequencer.sv
// Microcode sequencer: owns the micro-PC, times accesses to the asynchronous
// microcode EPROM, and latches each microword and computes the next address.
module mc_sequencer #(
   parameter int unsigned WAIT_CYCLES = 4,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [15:0] cond,
   input  logic [8:0]  dispatch_addr,
   output logic [8:0]  mc_addr,
   output logic        _mc_cs,
   output logic        _mc_oe,
   input  logic [63:0] mc_data,
   output logic [63:0] uinst,
   output logic        uinst_valid,
   output logic [8:0]  upc,
   output logic        halted,
   output logic        stack_err
);

   localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [1:0] {S_PEND, S_ACCESS, S_LATCH, S_EXEC} state_t;
   typedef enum logic [2:0] {
      OP_NEXT, OP_JUMP, OP_CJUMP, OP_DISPATCH, OP_CALL, OP_RET, OP_WAIT, OP_HALT
   } op_t;

   state_t         state;
   state_t         state_nxt;
   logic [3:0]     wait_cnt;
   logic [SPW-1:0] sp;
   logic [8:0]     stack [STACK_DEPTH];

   op_t        op;
   logic [8:0] target;
   logic [3:0] cond_sel;
   logic       c;
   logic [8:0] upc_inc;
   logic       access_done;
   logic       stack_full;
   logic       stack_empty;
   logic       advance;
   logic [AW-1:0] push_idx;
   logic [AW-1:0] pop_idx;

   assign op          = op_t'(uinst[63:61]);
   assign target      = uinst[60:52];
   assign cond_sel    = uinst[51:48];
   assign c           = cond[cond_sel] ^ uinst[47];
   assign upc_inc     = upc + 9'd1;
   assign access_done = (wait_cnt == 4'(WAIT_CYCLES - 1));
   assign stack_full  = (sp == SPW'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign push_idx    = sp[AW-1:0];
   assign pop_idx     = AW'(sp - SPW'(1));
   // A microword acts only in an unstalled EXEC cycle; once halted nothing advances.
   assign advance     = (state == S_EXEC) && !stall && !halted;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_PEND;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_PEND:   state_nxt = S_ACCESS;
         S_ACCESS: if (access_done) state_nxt = S_LATCH;
         S_LATCH:  state_nxt = S_EXEC;
         S_EXEC: begin
            if (advance && (op != OP_HALT) && !((op == OP_WAIT) && !c))
               state_nxt = S_ACCESS;
         end
         default:  state_nxt = S_PEND;
      endcase
   end

   always_comb begin
      mc_addr = upc;
      _mc_cs  = !((state == S_ACCESS) || (state == S_LATCH));
      _mc_oe  = !((state == S_ACCESS) || (state == S_LATCH));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         upc         <= '0;
         uinst       <= '0;
         uinst_valid <= 1'b0;
         halted      <= 1'b0;
         stack_err   <= 1'b0;
         sp          <= '0;
         wait_cnt    <= '0;
      end else begin
         uinst_valid <= 1'b0;
         case (state)
            S_ACCESS: wait_cnt <= access_done ? '0 : wait_cnt + 4'd1;
            S_LATCH: begin
               uinst       <= mc_data;
               uinst_valid <= 1'b1;
            end
            S_EXEC: begin
               if (advance) begin
                  case (op)
                     OP_NEXT:     upc <= upc_inc;
                     OP_JUMP:     upc <= target;
                     OP_CJUMP:    upc <= c ? target : upc_inc;
                     OP_DISPATCH: upc <= dispatch_addr;
                     OP_CALL: begin
                        upc <= target;
                        if (stack_full) stack_err <= 1'b1;
                        else            sp <= sp + SPW'(1);
                     end
                     OP_RET: begin
                        if (stack_empty) begin
                           stack_err <= 1'b1;
                           upc       <= '0;
                        end else begin
                           upc <= stack[pop_idx];
                           sp  <= sp - SPW'(1);
                        end
                     end
                     OP_WAIT:     if (c) upc <= upc_inc;
                     OP_HALT:     halted <= 1'b1;
                     default:     ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (advance && (op == OP_CALL) && !stack_full)
         stack[push_idx] <= upc_inc;
   end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: behavioural EPROM plus a queue of expected fetch addresses.
module tb_mc_sequencer;

   localparam logic [2:0] OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_CJUMP = 3'd2, OP_DISPATCH = 3'd3;
   localparam logic [2:0] OP_CALL = 3'd4, OP_RET = 3'd5, OP_WAIT = 3'd6, OP_HALT = 3'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic [15:0] cond = '0;
   logic [8:0]  dispatch_addr = '0;
   logic [8:0]  mc_addr;
   logic        mc_cs_n;
   logic        mc_oe_n;
   logic [63:0] mc_data;
   logic [63:0] uinst;
   logic        uinst_valid;
   logic [8:0]  upc;
   logic        halted;
   logic        stack_err;

   logic [63:0] rom [512];
   int          exp_q [$];
   int          vectors = 0;
   int          miscompares = 0;

   mc_sequencer #(.WAIT_CYCLES(4), .STACK_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .cond(cond), .dispatch_addr(dispatch_addr),
      .mc_addr(mc_addr), ._mc_cs(mc_cs_n), ._mc_oe(mc_oe_n), .mc_data(mc_data),
      .uinst(uinst), .uinst_valid(uinst_valid), .upc(upc), .halted(halted), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   // Undriven bus is modelled as a recognisable junk pattern.
   assign mc_data = mc_oe_n ? 64'hBAD0_BAD0_BAD0_BAD0 : rom[mc_addr];

   function automatic logic [63:0] mkw(input logic [2:0] op, input logic [8:0] tgt,
                                       input logic [3:0] sel, input logic inv, input int pay);
      return {op, tgt, sel, inv, 47'(pay)};
   endfunction

   task automatic begin_test();
      reset = 1'b1;
      stall = 1'b0;
      cond  = '0;
      dispatch_addr = '0;
      exp_q.delete();
      for (int i = 0; i < 512; i++) rom[i] = mkw(OP_HALT, 9'd0, 4'd0, 1'b0, i * 32'h9E37_79B1);
   endtask

   task automatic release_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic step_until_valid(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (uinst_valid) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      vectors++;
      if (mc_addr !== 9'd0 || mc_cs_n !== 1'b1 || mc_oe_n !== 1'b1 || uinst !== 64'd0 ||
          uinst_valid !== 1'b0 || upc !== 9'd0 || halted !== 1'b0 || stack_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state got addr=%03h cs=%b oe=%b uinst=%016h v=%b upc=%03h h=%b e=%b required all zero, cs=oe=1",
                  mc_addr, mc_cs_n, mc_oe_n, uinst, uinst_valid, upc, halted, stack_err);
      end
   endtask

   task automatic test_sequential();
      int run = 0;
      int last_v = -1;
      int a;
      begin_test();
      for (int i = 0; i < 3; i++) rom[i] = mkw(OP_NEXT, 9'(i * 7), 4'(i), 1'b0, 32'h1234_5670 + i);
      for (int i = 0; i < 4; i++) exp_q.push_back(i);
      release_reset();
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (!mc_cs_n) begin
            if (run == 0 && exp_q.size() > 0) begin
               vectors++;
               if (mc_addr !== 9'(exp_q[0]) || mc_oe_n !== 1'b0) begin
                  miscompares++;
                  $display("FAIL seq_addr got addr=%03h oe=%b required addr=%03h oe=0", mc_addr, mc_oe_n, exp_q[0]);
               end
            end
            run++;
         end else if (run != 0) begin
            vectors++;
            if (run != 5) begin
               miscompares++;
               $display("FAIL seq_enable_len got %0d clocks required 5", run);
            end
            run = 0;
         end
         if (uinst_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL seq_extra_valid got valid at upc=%03h required none", upc);
            end else begin
               a = exp_q.pop_front();
               vectors++;
               if (upc !== 9'(a) || uinst !== rom[a]) begin
                  miscompares++;
                  $display("FAIL seq_fetch got upc=%03h uinst=%016h required upc=%03h uinst=%016h", upc, uinst, a, rom[a]);
               end
            end
            if (last_v >= 0) begin
               vectors++;
               if (cyc - last_v != 6) begin
                  miscompares++;
                  $display("FAIL seq_valid_period got %0d required 6", cyc - last_v);
               end
            end
            last_v = cyc;
         end
      end
      vectors++;
      if (exp_q.size() != 0 || halted !== 1'b1) begin
         miscompares++;
         $display("FAIL seq_end got pending=%0d halted=%b required pending=0 halted=1", exp_q.size(), halted);
      end
   endtask

   task automatic test_call_ret();
      bit got;
      int a;
      begin_test();
      rom[0]     = mkw(OP_CALL, 9'h100, 4'd0, 1'b0, 32'h11);
      rom[9'h100] = mkw(OP_RET, 9'h0AA, 4'd0, 1'b0, 32'h22);
      exp_q.push_back(0); exp_q.push_back('h100); exp_q.push_back(1);
      release_reset();
      while (exp_q.size() > 0) begin
         step_until_valid(40, got);
         a = exp_q.pop_front();
         vectors++;
         if (!got || upc !== 9'(a) || uinst !== rom[a]) begin
            miscompares++;
            $display("FAIL callret_fetch got valid=%b upc=%03h uinst=%016h required upc=%03h uinst=%016h", got, upc, uinst, a, rom[a]);
         end
      end
      @(negedge clk);
      vectors++;
      if (stack_err !== 1'b0 || halted !== 1'b1) begin
         miscompares++;
         $display("FAIL callret_flags got err=%b halted=%b required err=0 halted=1", stack_err, halted);
      end
   endtask

   task automatic test_cjump();
      bit got;
      int a;
      logic [15:0] cv  [3] = '{16'h0008, 16'h0008, 16'hFFF7};
      logic        inv [3] = '{1'b0, 1'b1, 1'b0};
      int          dst [3] = '{'h050, 1, 1};
      for (int r = 0; r < 3; r++) begin
         begin_test();
         cond   = cv[r];
         rom[0] = mkw(OP_CJUMP, 9'h050, 4'd3, inv[r], 32'h33 + r);
         exp_q.push_back(0); exp_q.push_back(dst[r]);
         release_reset();
         while (exp_q.size() > 0) begin
            step_until_valid(40, got);
            a = exp_q.pop_front();
            vectors++;
            if (!got || upc !== 9'(a) || uinst !== rom[a]) begin
               miscompares++;
               $display("FAIL cjump_run%0d got valid=%b upc=%03h required upc=%03h", r, got, upc, a);
            end
         end
      end
   endtask

   task automatic test_dispatch();
      bit got;
      int a;
      begin_test();
      dispatch_addr = 9'h1A0;
      rom[0] = mkw(OP_DISPATCH, 9'h011, 4'd0, 1'b0, 32'h44);
      exp_q.push_back(0);
      release_reset();
      step_until_valid(40, got);
      a = exp_q.pop_front();
      vectors++;
      if (!got || upc !== 9'(a)) begin
         miscompares++;
         $display("FAIL dispatch_first got valid=%b upc=%03h required upc=%03h", got, upc, a);
      end
      exp_q.push_back('h1A0);
      @(negedge clk);
      vectors++;
      if (mc_addr !== 9'h1A0 || mc_cs_n !== 1'b0) begin
         miscompares++;
         $display("FAIL dispatch_addr got addr=%03h cs=%b required addr=1a0 cs=0", mc_addr, mc_cs_n);
      end
      step_until_valid(40, got);
      a = exp_q.pop_front();
      vectors++;
      if (!got || upc !== 9'(a) || uinst !== rom[a]) begin
         miscompares++;
         $display("FAIL dispatch_fetch got valid=%b upc=%03h uinst=%016h required upc=%03h", got, upc, uinst, a);
      end
   endtask

   task automatic test_wait();
      bit got;
      int a;
      begin_test();
      rom[0] = mkw(OP_WAIT, 9'h077, 4'd0, 1'b0, 32'h55);
      exp_q.push_back(0);
      release_reset();
      step_until_valid(40, got);
      a = exp_q.pop_front();
      vectors++;
      if (!got || upc !== 9'(a)) begin
         miscompares++;
         $display("FAIL wait_first got valid=%b upc=%03h required upc=%03h", got, upc, a);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if (uinst_valid !== 1'b0 || mc_cs_n !== 1'b1 || mc_oe_n !== 1'b1 || upc !== 9'd0) begin
            miscompares++;
            $display("FAIL wait_hold got v=%b cs=%b oe=%b upc=%03h required v=0 cs=1 oe=1 upc=000", uinst_valid, mc_cs_n, mc_oe_n, upc);
         end
      end
      cond = 16'h0001;
      exp_q.push_back(1);
      step_until_valid(40, got);
      a = exp_q.pop_front();
      vectors++;
      if (!got || upc !== 9'(a) || uinst !== rom[a]) begin
         miscompares++;
         $display("FAIL wait_release got valid=%b upc=%03h required upc=%03h", got, upc, a);
      end
   endtask

   task automatic test_stall();
      bit got;
      int a;
      begin_test();
      rom[0] = mkw(OP_NEXT, 9'h0, 4'd0, 1'b0, 32'h66);
      exp_q.push_back(0);
      release_reset();
      stall = 1'b1;
      step_until_valid(40, got);
      a = exp_q.pop_front();
      vectors++;
      if (!got || upc !== 9'(a) || uinst !== rom[a]) begin
         miscompares++;
         $display("FAIL stall_fetch got valid=%b upc=%03h required upc=%03h", got, upc, a);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vectors++;
         if (mc_cs_n !== 1'b1 || upc !== 9'd0 || uinst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold got cs=%b upc=%03h v=%b required cs=1 upc=000 v=0", mc_cs_n, upc, uinst_valid);
         end
      end
      stall = 1'b0;
      exp_q.push_back(1);
      step_until_valid(40, got);
      a = exp_q.pop_front();
      vectors++;
      if (!got || upc !== 9'(a)) begin
         miscompares++;
         $display("FAIL stall_release got valid=%b upc=%03h required upc=%03h", got, upc, a);
      end
   endtask

   task automatic test_stack_overflow();
      bit got;
      int a;
      int k = 0;
      begin_test();
      rom[0]     = mkw(OP_CALL, 9'h010, 4'd0, 1'b0, 32'h70);
      rom[9'h10] = mkw(OP_CALL, 9'h020, 4'd0, 1'b0, 32'h71);
      rom[9'h20] = mkw(OP_CALL, 9'h030, 4'd0, 1'b0, 32'h72);
      rom[9'h30] = mkw(OP_CALL, 9'h040, 4'd0, 1'b0, 32'h73);
      rom[9'h40] = mkw(OP_CALL, 9'h050, 4'd0, 1'b0, 32'h74);
      exp_q.push_back(0); exp_q.push_back('h10); exp_q.push_back('h20);
      exp_q.push_back('h30); exp_q.push_back('h40); exp_q.push_back('h50);
      release_reset();
      while (exp_q.size() > 0) begin
         step_until_valid(40, got);
         a = exp_q.pop_front();
         vectors++;
         if (!got || upc !== 9'(a) || stack_err !== (k == 5)) begin
            miscompares++;
            $display("FAIL overflow_step%0d got valid=%b upc=%03h err=%b required upc=%03h err=%b", k, got, upc, stack_err, a, k == 5);
         end
         k++;
      end
   endtask

   task automatic test_ret_empty();
      bit got;
      int a;
      int k = 0;
      begin_test();
      rom[0] = mkw(OP_NEXT, 9'h0, 4'd0, 1'b0, 32'h80);
      rom[1] = mkw(OP_RET, 9'h1FF, 4'd0, 1'b0, 32'h81);
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
      release_reset();
      while (exp_q.size() > 0) begin
         step_until_valid(40, got);
         a = exp_q.pop_front();
         vectors++;
         if (!got || upc !== 9'(a) || stack_err !== (k == 2)) begin
            miscompares++;
            $display("FAIL underflow_step%0d got valid=%b upc=%03h err=%b required upc=%03h err=%b", k, got, upc, stack_err, a, k == 2);
         end
         k++;
      end
   endtask

   task automatic test_reset_mid_access();
      bit got;
      int a;
      begin_test();
      rom[0] = mkw(OP_JUMP, 9'h033, 4'd0, 1'b0, 32'h90);
      exp_q.push_back(0);
      release_reset();
      step_until_valid(40, got);
      a = exp_q.pop_front();
      vectors++;
      if (!got || upc !== 9'(a)) begin
         miscompares++;
         $display("FAIL midreset_fetch got valid=%b upc=%03h required upc=%03h", got, upc, a);
      end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (upc !== 9'h033 || mc_cs_n !== 1'b0 || uinst !== rom[0]) begin
         miscompares++;
         $display("FAIL midreset_pre got upc=%03h cs=%b uinst=%016h required upc=033 cs=0", upc, mc_cs_n, uinst);
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (mc_cs_n !== 1'b1 || mc_oe_n !== 1'b1 || upc !== 9'd0 || uinst !== 64'd0 || mc_addr !== 9'd0) begin
         miscompares++;
         $display("FAIL midreset_async got cs=%b oe=%b upc=%03h uinst=%016h addr=%03h required 1 1 000 0 000", mc_cs_n, mc_oe_n, upc, uinst, mc_addr);
      end
   endtask

   task automatic test_halt();
      bit got;
      int a;
      begin_test();
      rom[0] = mkw(OP_NEXT, 9'h0, 4'd0, 1'b0, 32'hA0);
      exp_q.push_back(0); exp_q.push_back(1);
      release_reset();
      while (exp_q.size() > 0) begin
         step_until_valid(40, got);
         a = exp_q.pop_front();
         vectors++;
         if (!got || upc !== 9'(a) || uinst !== rom[a]) begin
            miscompares++;
            $display("FAIL halt_fetch got valid=%b upc=%03h required upc=%03h", got, upc, a);
         end
      end
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         vectors++;
         if (halted !== 1'b1 || mc_addr !== 9'd1 || mc_cs_n !== 1'b1 || uinst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_frozen got h=%b addr=%03h cs=%b v=%b required h=1 addr=001 cs=1 v=0", halted, mc_addr, mc_cs_n, uinst_valid);
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sequential();
      test_call_ret();
      test_cjump();
      test_dispatch();
      test_wait();
      test_stall();
      test_stack_overflow();
      test_ret_empty();
      test_reset_mid_access();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
